// File: rtl/opb_dec_pkg.sv
// Shared types and constants for the OPB-to-register-decoder bridge.
// Holds the FSM state encoding, default register window and counter width.
package opb_dec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT,
        ACK
    } opbState_e;

    localparam logic [31:0] DEFAULT_BASEADDR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HIGHADDR = 32'h000B_FFFF;

    localparam int CNT_W = 4;

endpackage

// File: rtl/opb_dec_bridge.sv
// OPB slave front-end turning single-beat transfers into one-cycle decoder strobes.
// Optional byte-enable checking is enabled by defining OPB_DEC_BE_CHECK_EN.
module opb_dec_bridge
    import opb_dec_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = DEFAULT_BASEADDR,
    parameter logic [31:0] C_HIGHADDR = DEFAULT_HIGHADDR,
    parameter int          RD_LAT     = 1
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST,
    input  logic        OPB_select,
    input  logic        OPB_RNW,
    input  logic [31:0] OPB_ABus,
    input  logic [31:0] OPB_DBus,
    input  logic [3:0]  OPB_BE,
    output logic [31:0] Sl_DBus,
    output logic        Sl_xferAck,
    output logic        Sl_errAck,
    output logic        Sl_retry,
    output logic        Sl_toutSup,
    output logic        DEC_RE,
    output logic        DEC_WE,
    output logic [31:0] DEC_ADDR,
    output logic [31:0] DEC_DI,
    input  logic [31:0] DEC_DO
);

    opbState_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rnw_q;
    logic              decRe_q;
    logic              decWe_q;
    logic [31:0]       decAddr_q;
    logic [31:0]       decAddr_d;
    logic [31:0]       decDi_q;
    logic [31:0]       slDbus_q;
    logic              xferAck_q;
    logic              errAck_q;
    logic              toutSup_q;
    logic              inWindow;
    logic              beOk;

    // Addresses below the base wrap to a huge offset, so one compare covers both bounds.
    assign decAddr_d = OPB_ABus - C_BASEADDR;
    assign inWindow  = (decAddr_d <= (C_HIGHADDR - C_BASEADDR));

`ifdef OPB_DEC_BE_CHECK_EN
    assign beOk = (OPB_BE == 4'hF);
`else
    logic unusedBe;
    assign unusedBe = ^OPB_BE;
    assign beOk     = 1'b1;
`endif

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rnw_q     <= 1'b0;
            decRe_q   <= 1'b0;
            decWe_q   <= 1'b0;
            decAddr_q <= '0;
            decDi_q   <= '0;
            slDbus_q  <= '0;
            xferAck_q <= 1'b0;
            errAck_q  <= 1'b0;
            toutSup_q <= 1'b0;
        end else begin
            decRe_q   <= 1'b0;
            decWe_q   <= 1'b0;
            xferAck_q <= 1'b0;
            errAck_q  <= 1'b0;
            slDbus_q  <= '0;
            toutSup_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (OPB_select && inWindow) begin
                        if (!beOk) begin
                            errAck_q <= 1'b1;
                            state_q  <= ACK;
                        end else begin
                            decAddr_q <= decAddr_d;
                            decDi_q   <= OPB_DBus;
                            rnw_q     <= OPB_RNW;
                            decRe_q   <= OPB_RNW;
                            decWe_q   <= !OPB_RNW;
                            toutSup_q <= 1'b1;
                            state_q   <= STROBE;
                        end
                    end
                end
                STROBE: begin
                    if (!OPB_select) begin
                        state_q <= IDLE;
                    end else if (rnw_q) begin
                        cnt_q     <= CNT_W'(RD_LAT);
                        toutSup_q <= 1'b1;
                        state_q   <= WAIT;
                    end else begin
                        xferAck_q <= 1'b1;
                        state_q   <= ACK;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (!OPB_select) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_W'(1)) begin
                        xferAck_q <= 1'b1;
                        slDbus_q  <= DEC_DO;
                        state_q   <= ACK;
                    end else begin
                        toutSup_q <= 1'b1;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Sl_DBus    = slDbus_q;
    assign Sl_xferAck = xferAck_q;
    assign Sl_errAck  = errAck_q;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = toutSup_q;
    assign DEC_RE     = decRe_q;
    assign DEC_WE     = decWe_q;
    assign DEC_ADDR   = decAddr_q;
    assign DEC_DI     = decDi_q;

endmodule

// File: tb/tb_opb_dec_bridge.sv
// Self-checking bench for opb_dec_bridge: two instances (read latency 1 and 4)
// driven by directed and random transfers checked against a cycle-timeline model.
module tb_opb_dec_bridge;

    localparam logic [31:0] WIN_LO = 32'h0000_0000;
    localparam logic [31:0] WIN_HI = 32'h000B_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel [2];
    logic        rnw;
    logic [31:0] abus;
    logic [31:0] dbus;
    logic [31:0] decDo;
    logic [3:0]  be;

    logic [31:0] slDbus  [2];
    logic [31:0] decAddr [2];
    logic [31:0] decDi   [2];
    logic        xferAck [2];
    logic        errAck  [2];
    logic        retry   [2];
    logic        toutSup [2];
    logic        decRe   [2];
    logic        decWe   [2];

    // Last address offset / write data each instance should be presenting.
    logic [31:0] expAddr [2];
    logic [31:0] expDi   [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    opb_dec_bridge #(.C_BASEADDR(WIN_LO), .C_HIGHADDR(WIN_HI), .RD_LAT(1)) dutLat1 (
        .OPB_CLK(clk), .OPB_RST(rst), .OPB_select(sel[0]), .OPB_RNW(rnw),
        .OPB_ABus(abus), .OPB_DBus(dbus), .OPB_BE(be),
        .Sl_DBus(slDbus[0]), .Sl_xferAck(xferAck[0]), .Sl_errAck(errAck[0]),
        .Sl_retry(retry[0]), .Sl_toutSup(toutSup[0]), .DEC_RE(decRe[0]),
        .DEC_WE(decWe[0]), .DEC_ADDR(decAddr[0]), .DEC_DI(decDi[0]), .DEC_DO(decDo)
    );

    opb_dec_bridge #(.C_BASEADDR(WIN_LO), .C_HIGHADDR(WIN_HI), .RD_LAT(4)) dutLat4 (
        .OPB_CLK(clk), .OPB_RST(rst), .OPB_select(sel[1]), .OPB_RNW(rnw),
        .OPB_ABus(abus), .OPB_DBus(dbus), .OPB_BE(be),
        .Sl_DBus(slDbus[1]), .Sl_xferAck(xferAck[1]), .Sl_errAck(errAck[1]),
        .Sl_retry(retry[1]), .Sl_toutSup(toutSup[1]), .DEC_RE(decRe[1]),
        .DEC_WE(decWe[1]), .DEC_ADDR(decAddr[1]), .DEC_DI(decDi[1]), .DEC_DO(decDo)
    );

    // One master transfer on instance d. Cycle k=1 is the cycle after the select-sampling
    // edge; the expected timeline is derived from the transfer kind and read latency.
    task automatic runXfer(input int d, input logic r, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] rdData,
                           input logic [3:0] bytes, input int abortAt, input int tail);
        int          lat;
        int          o;
        longint      a;
        bit          inWin;
        bit          errCase;
        bit          live;
        bit          acks;
        bit          active;
        int          ackCyc;
        int          ncyc;
        logic [5:0]  wantCtl;
        logic [5:0]  gotCtl;
        logic [31:0] wantBus;
        lat     = (d == 1) ? 4 : 1;
        o       = 1 - d;
        a       = longint'(addr);
        inWin   = (a >= longint'(WIN_LO)) && (a <= longint'(WIN_HI));
        errCase = 1'b0;
`ifdef OPB_DEC_BE_CHECK_EN
        errCase = inWin && (bytes != 4'hF);
`endif
        live    = inWin && !errCase;
        ackCyc  = r ? 2 + lat : 2;
        ncyc    = ackCyc + tail;
        acks    = live && (abortAt == 0 || abortAt >= ackCyc);

        @(negedge clk);
        sel[d] = 1'b1; rnw = r; abus = addr; dbus = data; be = bytes; decDo = $urandom;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            active  = (abortAt == 0) || (k <= abortAt);
            wantCtl = {live && k == 1 && r,
                       live && k == 1 && !r,
                       acks && k == ackCyc,
                       errCase && k == 1,
                       live && active && (k <= (r ? 1 + lat : 1)),
                       1'b0};
            wantBus = (acks && r && k == ackCyc) ? rdData : 32'h0;
            if (live && k == 1) begin
                expAddr[d] = addr - WIN_LO;
                expDi[d]   = data;
            end
            gotCtl = {decRe[d], decWe[d], xferAck[d], errAck[d], toutSup[d], retry[d]};
            total++;
            if (gotCtl !== wantCtl) begin
                bad++;
                $display("[TB] FAIL ctl dut=%0d k=%0d addr=%h got=%b want=%b (re,we,ack,err,tout,retry)",
                         d, k, addr, gotCtl, wantCtl);
            end
            total++;
            if (slDbus[d] !== wantBus) begin
                bad++;
                $display("[TB] FAIL rdata dut=%0d k=%0d got=%h want=%h", d, k, slDbus[d], wantBus);
            end
            total++;
            if (decAddr[d] !== expAddr[d]) begin
                bad++;
                $display("[TB] FAIL dec_addr dut=%0d k=%0d got=%h want=%h", d, k, decAddr[d], expAddr[d]);
            end
            total++;
            if (decDi[d] !== expDi[d]) begin
                bad++;
                $display("[TB] FAIL dec_di dut=%0d k=%0d got=%h want=%h", d, k, decDi[d], expDi[d]);
            end
            total++;
            if ({decRe[o], decWe[o], xferAck[o], toutSup[o]} !== 4'b0) begin
                bad++;
                $display("[TB] FAIL idle_quiet dut=%0d k=%0d got=%b want=0000", o, k,
                         {decRe[o], decWe[o], xferAck[o], toutSup[o]});
            end
            decDo = (k == 1 + lat) ? rdData : $urandom;
            if (k == abortAt || k == ackCyc || k == ncyc || (errCase && k == 1))
                sel[d] = 1'b0;
        end
    endtask

    task automatic checkAllZero(input string tag);
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({slDbus[d], decAddr[d], decDi[d], xferAck[d], errAck[d], retry[d],
                 toutSup[d], decRe[d], decWe[d]} !== 102'b0) begin
                bad++;
                $display("[TB] FAIL %s dut=%0d got ack=%b re=%b we=%b tout=%b addr=%h di=%h rd=%h want all 0",
                         tag, d, xferAck[d], decRe[d], decWe[d], toutSup[d], decAddr[d], decDi[d], slDbus[d]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sel[0] = 1'b0; sel[1] = 1'b0; rnw = 1'b0;
        abus = '0; dbus = '0; be = 4'hF; decDo = '0;
        for (int d = 0; d < 2; d++) begin expAddr[d] = '0; expDi[d] = '0; end
        repeat (2) @(negedge clk);
        checkAllZero("reset_state");
        rst = 1'b0;
    endtask

    task automatic test_write();
        runXfer(0, 1'b0, 32'h0001_0000, 32'hDEAD_BEEF, 32'h0, 4'hF, 0, 2);
        runXfer(1, 1'b0, 32'h0000_0124, 32'hCAFE_0001, 32'h0, 4'hF, 0, 2);
    endtask

    task automatic test_read();
        runXfer(0, 1'b1, 32'h0004_0004, 32'h0, 32'h1234_5678, 4'hF, 0, 2);
        runXfer(1, 1'b1, 32'h0008_0010, 32'h0, 32'h8765_4321, 4'hF, 0, 2);
    endtask

    task automatic test_window_edges();
        runXfer(0, 1'b1, 32'h000C_0000, 32'h0, 32'hAAAA_5555, 4'hF, 0, 18);
        runXfer(0, 1'b1, 32'h000B_FFFF, 32'h0, 32'h0BAD_F00D, 4'hF, 0, 1);
        runXfer(1, 1'b0, 32'h0000_0000, 32'h1111_2222, 32'h0, 4'hF, 0, 1);
        runXfer(1, 1'b0, 32'hFFFF_FFFC, 32'h3333_4444, 32'h0, 4'hF, 0, 3);
    endtask

    task automatic test_abort();
        runXfer(0, 1'b1, 32'h0000_0100, 32'h0, 32'h5A5A_5A5A, 4'hF, 2, 3);
        runXfer(0, 1'b1, 32'h0000_0200, 32'h0, 32'hC3C3_3C3C, 4'hF, 0, 2);
        runXfer(1, 1'b0, 32'h0000_0300, 32'h7777_8888, 32'h0, 4'hF, 1, 3);
        runXfer(1, 1'b1, 32'h0000_0400, 32'h0, 32'h0F0F_F0F0, 4'hF, 3, 2);
    endtask

    task automatic test_back_to_back();
        runXfer(0, 1'b0, 32'h0000_1000, 32'h0101_0101, 32'h0, 4'hF, 0, 0);
        runXfer(0, 1'b1, 32'h0000_1004, 32'h0, 32'h0202_0202, 4'hF, 0, 0);
        runXfer(0, 1'b0, 32'h0000_1008, 32'h0303_0303, 32'h0, 4'hF, 0, 2);
    endtask

    task automatic test_byte_enables();
        runXfer(0, 1'b0, 32'h0000_2000, 32'h4444_5555, 32'h0, 4'h3, 0, 2);
        runXfer(1, 1'b1, 32'h0000_2004, 32'h0, 32'h6666_7777, 4'h8, 0, 2);
    endtask

    // Reset in the middle of a latency-4 read must clear everything immediately.
    task automatic test_reset_mid();
        @(negedge clk);
        sel[1] = 1'b1; rnw = 1'b1; abus = 32'h0000_3000; dbus = 32'h9999_AAAA; be = 4'hF;
        repeat (3) @(negedge clk);
        total++;
        if (toutSup[1] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_wait_tout got=%b want=1", toutSup[1]);
        end
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin expAddr[d] = '0; expDi[d] = '0; end
        checkAllZero("async_reset");
        sel[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++;
            if ({xferAck[1], decRe[1], decWe[1], toutSup[1]} !== 4'b0) begin
                bad++;
                $display("[TB] FAIL post_reset_quiet k=%0d got=%b want=0000", k,
                         {xferAck[1], decRe[1], decWe[1], toutSup[1]});
            end
        end
    endtask

    task automatic test_random();
        int          d;
        logic        r;
        logic [31:0] addr;
        int          abortAt;
        logic [3:0]  bytes;
        for (int i = 0; i < 40; i++) begin
            d = int'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: addr = $urandom_range(32'h000C_0000, 32'hFFFF_FFFF);
                1: addr = WIN_HI - 32'($urandom_range(0, 1));
                2: addr = WIN_HI + 32'd1;
                default: addr = $urandom_range(0, WIN_HI);
            endcase
            abortAt = 0;
            if ($urandom_range(0, 4) == 0)
                abortAt = int'($urandom_range(1, r ? ((d == 1) ? 5 : 2) : 1));
            bytes = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            runXfer(d, r, addr, $urandom, $urandom, bytes, abortAt, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_window_edges();
        test_abort();
        test_back_to_back();
        test_byte_enables();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/opb_dec_bridge.md
# opb_dec_bridge

OPB slave front-end that sits directly upstream of the register address decoder. It accepts single-beat OPB read/write transfers addressed to the FPGA register window and converts them into the decoder's one-cycle DEC_RE/DEC_WE strobes with a window-relative DEC_ADDR. It captures the decoder's delayed read data (DEC_DO) and returns it on Sl_DBus with Sl_xferAck. A single FSM with a read-latency counter sequences each transfer.

## Interface
Parameters:
- C_BASEADDR, 32'h0000_0000, first byte address of the register window
- C_HIGHADDR, 32'h000B_FFFF, last byte address of the window (inclusive)
- RD_LAT, 1, cycles from DEC_RE high to DEC_DO valid; legal range 1..15

Ports:
- OPB_CLK  in  1  bus clock
- OPB_RST  in  1  reset, asynchronous, active-high
- OPB_select  in  1  master transfer request
- OPB_RNW  in  1  1 = read, 0 = write
- OPB_ABus  in  32  byte address
- OPB_DBus  in  32  write data
- OPB_BE  in  4  byte enables
- Sl_DBus  out  32  read data; zero except in the ack cycle
- Sl_xferAck  out  1  one-cycle transfer acknowledge
- Sl_errAck  out  1  one-cycle error acknowledge (only with OPB_DEC_BE_CHECK_EN)
- Sl_retry  out  1  tied 0
- Sl_toutSup  out  1  high while the FSM is in STROBE or WAIT
- DEC_RE  out  1  decoder read strobe, one cycle
- DEC_WE  out  1  decoder write strobe, one cycle
- DEC_ADDR  out  32  OPB_ABus − C_BASEADDR, registered
- DEC_DI  out  32  registered write data, valid with DEC_WE
- DEC_DO  in  32  decoder read data

## Operation
- States: IDLE, STROBE, WAIT, ACK.
- IDLE: if OPB_select=1 and C_BASEADDR ≤ OPB_ABus ≤ C_HIGHADDR, register the address offset, RNW and OPB_DBus, then go to STROBE. An out-of-window address gets no response and stays IDLE.
- STROBE: exactly one cycle with DEC_RE=RNW or DEC_WE=!RNW.
  - Write: go to ACK.
  - Read: load cnt=RD_LAT and go to WAIT.
- WAIT: cnt decrements each cycle. When cnt==1, capture DEC_DO into the read-data register and go to ACK.
- ACK: Sl_xferAck=1 for one cycle. On a read, Sl_DBus = captured data; otherwise Sl_DBus = 0. Return to IDLE.
- IDLE samples OPB_select in the cycle after ACK, so back-to-back transfers are accepted with one idle cycle between them.
- Master abort: if OPB_select drops in STROBE or WAIT, go to IDLE with no ack. A strobe already issued is not retracted.
- DEC_ADDR and DEC_DI hold their last value between transfers. DEC_RE and DEC_WE are never high together.
- Reset: all outputs are 0, the FSM is in IDLE and cnt=0. Asserting reset mid-transfer aborts the transfer with no ack.

## Timing
- Edge T0 samples select. DEC_RE/DEC_WE are high in cycle T1.
- Write: Sl_xferAck is high in cycle T2.
- Read: DEC_DO is sampled at the end of cycle T1+RD_LAT. Sl_xferAck and Sl_DBus are valid in cycle T2+RD_LAT (T3 for RD_LAT=1).
- All outputs come directly from flops; there is no combinational path from OPB inputs to any output.

## Configuration
- OPB_DEC_BE_CHECK_EN defined:
  - In IDLE, an in-window transfer with OPB_BE≠4'hF issues no strobe and goes to ACK with Sl_errAck=1 and Sl_xferAck=0.
  - Sl_errAck is high in cycle T1.
- Not defined:
  - OPB_BE is ignored and every transfer is treated as a full word.
  - Sl_errAck is tied 0.

## Structure
- Package opb_dec_pkg holds:
  - the state enum (IDLE, STROBE, WAIT, ACK);
  - the default window constants 32'h0000_0000 and 32'h000B_FFFF;
  - the counter width localparam, 4 bits.
- No sub-module; the block is a single FSM with its datapath registers.

## Test plan
- Write 0x0001_0000, data 0xDEADBEEF -> DEC_WE high in T1 only, DEC_ADDR=0x10000, DEC_DI=0xDEADBEEF; Sl_xferAck in T2.
- Read 0x0004_0004 with RD_LAT=1, DEC_DO driven 0x1234_5678 in cycle T2 -> Sl_xferAck and Sl_DBus=0x12345678 in T3; Sl_DBus=0 in all other cycles.
- Read 0x000C_0000 (outside the window) -> no strobe and no ack for 20 cycles.
- Read with select dropped in T2 -> FSM returns to IDLE, no ack; the next read completes normally.
- Assert OPB_RST during WAIT with RD_LAT=4 -> all outputs 0 immediately and no ack after release.
- With OPB_DEC_BE_CHECK_EN, write with BE=4'h3 -> Sl_errAck in T1, DEC_WE never asserted.
